// File: rtl/fuec_13_8_pkg.sv
// Shared types and code dimensions for the FUEC(13,8) receive path.
// Codeword layout is {parity[4:0], data[7:0]}.
package fuec_13_8_pkg;

    localparam int N = 13;
    localparam int K = 8;
    localparam int R = 5;

    typedef logic [N-1:0] codeword_t;
    typedef logic [K-1:0] data_t;
    typedef logic [R-1:0] syndrome_t;

    typedef struct packed {
        logic no_error;
        logic corrected;
        logic uncorr;
    } status_t;

endpackage

// File: rtl/fuec_decoder_13_8.sv
// Combinational FUEC(13,8) decoder: odd-weight parity-check columns give single-error
// correction, and any even-weight nonzero syndrome (e.g. two flipped bits) is reported uncorrectable.
module fuec_decoder_13_8
    import fuec_13_8_pkg::*;
(
    input  codeword_t cw_i,
    output syndrome_t syn_o,
    output data_t     data_o,
    output logic      corrected_o,
    output logic      uncorr_o
);

    data_t     d;
    syndrome_t syn;
    codeword_t flip;

    assign d = cw_i[K-1:0];

    // Data columns: 07,0B,0D,0E,13,15,16,19; parity bit j has column (1 << j).
    assign syn[0] = cw_i[8]  ^ d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
    assign syn[1] = cw_i[9]  ^ d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    assign syn[2] = cw_i[10] ^ d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    assign syn[3] = cw_i[11] ^ d[1] ^ d[2] ^ d[3] ^ d[7];
    assign syn[4] = cw_i[12] ^ d[4] ^ d[5] ^ d[6] ^ d[7];

    always_comb begin
        flip = '0;
        case (syn)
            5'h07:   flip[0]  = 1'b1;
            5'h0B:   flip[1]  = 1'b1;
            5'h0D:   flip[2]  = 1'b1;
            5'h0E:   flip[3]  = 1'b1;
            5'h13:   flip[4]  = 1'b1;
            5'h15:   flip[5]  = 1'b1;
            5'h16:   flip[6]  = 1'b1;
            5'h19:   flip[7]  = 1'b1;
            5'h01:   flip[8]  = 1'b1;
            5'h02:   flip[9]  = 1'b1;
            5'h04:   flip[10] = 1'b1;
            5'h08:   flip[11] = 1'b1;
            5'h10:   flip[12] = 1'b1;
            default: flip     = '0;
        endcase
    end

    assign syn_o       = syn;
    assign data_o      = d ^ flip[K-1:0];
    assign corrected_o = |flip;
    assign uncorr_o    = (syn != '0) && !(|flip);

endmodule

// File: rtl/fuec_13_8_rx_pipe.sv
// Two-stage streaming FUEC(13,8) receiver with saturating error counters.
// Define FUEC_ERR_LOG_EN to add a sticky log of the first uncorrectable word.
module fuec_13_8_rx_pipe
    import fuec_13_8_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DROP_UNCORR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_data,
    output logic             out_no_error,
    output logic             out_corrected,
    output logic             out_uncorr,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
`ifdef FUEC_ERR_LOG_EN
    ,
    output logic             err_log_valid,
    output logic [R-1:0]     err_log_syn,
    output logic [N-1:0]     err_log_cw
`endif
);

    logic             v1_q, v1_d;
    codeword_t        cw1_q, cw1_d;
    logic             v2_q, v2_d;
    data_t            data2_q, data2_d;
    status_t          st2_q, st2_d;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic [CNT_W-1:0] uncorr_q, uncorr_d;

    syndrome_t syn;
    data_t     dec_data;
    logic      dec_corr;
    logic      dec_unc;
    status_t   st1;

    logic adv1, adv2, xfer, drop, load2;

    fuec_decoder_13_8 u_dec (
        .cw_i        (cw1_q),
        .syn_o       (syn),
        .data_o      (dec_data),
        .corrected_o (dec_corr),
        .uncorr_o    (dec_unc)
    );

    assign st1.no_error  = (syn == '0);
    assign st1.corrected = dec_corr;
    assign st1.uncorr    = dec_unc;

    // Ready ripples back combinationally so a full pipe still moves every cycle.
    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;
    assign xfer     = v1_q && adv2;
    assign drop     = xfer && (DROP_UNCORR != 0) && st1.uncorr;
    assign load2    = xfer && !drop;

    always_comb begin
        v1_d     = v1_q;
        cw1_d    = cw1_q;
        v2_d     = v2_q;
        data2_d  = data2_q;
        st2_d    = st2_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;

        if (adv1) begin
            v1_d = in_valid;
        end
        if (in_valid && adv1) begin
            cw1_d = in_cw;
        end

        if (adv2) begin
            v2_d = load2;
        end
        // An uncorrectable word is forwarded with its raw byte rather than a guessed fix.
        if (load2) begin
            data2_d = st1.uncorr ? cw1_q[K-1:0] : dec_data;
            st2_d   = st1;
        end

        if (clr_cnt) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else begin
            if (xfer && st1.corrected && (corr_q != '1)) begin
                corr_d = corr_q + CNT_W'(1);
            end
            if (xfer && st1.uncorr && (uncorr_q != '1)) begin
                uncorr_d = uncorr_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            cw1_q    <= '0;
            v2_q     <= 1'b0;
            data2_q  <= '0;
            st2_q    <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            v1_q     <= v1_d;
            cw1_q    <= cw1_d;
            v2_q     <= v2_d;
            data2_q  <= data2_d;
            st2_q    <= st2_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    assign out_valid     = v2_q;
    assign out_data      = data2_q;
    assign out_no_error  = st2_q.no_error;
    assign out_corrected = st2_q.corrected;
    assign out_uncorr    = st2_q.uncorr;
    assign corr_cnt      = corr_q;
    assign uncorr_cnt    = uncorr_q;

`ifdef FUEC_ERR_LOG_EN
    logic      log_v_q, log_v_d;
    syndrome_t log_syn_q, log_syn_d;
    codeword_t log_cw_q, log_cw_d;

    // Sticky capture of the first uncorrectable word; a coincident clear takes priority.
    always_comb begin
        log_v_d   = log_v_q;
        log_syn_d = log_syn_q;
        log_cw_d  = log_cw_q;
        if (clr_cnt) begin
            log_v_d   = 1'b0;
            log_syn_d = '0;
            log_cw_d  = '0;
        end else if (xfer && st1.uncorr && !log_v_q) begin
            log_v_d   = 1'b1;
            log_syn_d = syn;
            log_cw_d  = cw1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_v_q   <= 1'b0;
            log_syn_q <= '0;
            log_cw_q  <= '0;
        end else begin
            log_v_q   <= log_v_d;
            log_syn_q <= log_syn_d;
            log_cw_q  <= log_cw_d;
        end
    end

    assign err_log_valid = log_v_q;
    assign err_log_syn   = log_syn_q;
    assign err_log_cw    = log_cw_q;
`endif

endmodule

// File: tb/tb_fuec_13_8_rx_pipe.sv
// Self-checking bench for fuec_13_8_rx_pipe: a default instance plus a CNT_W=2,
// DROP_UNCORR=1 instance, checked against a search-based decoding model.
module tb_fuec_13_8_rx_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default instance
    logic        inValid, inReady, outValid, outReady, clrCnt;
    logic [12:0] inCw;
    logic [7:0]  outData;
    logic        outNoError, outCorrected, outUncorr;
    logic [15:0] corrCnt, uncorrCnt;

    // Small-counter, drop-uncorrectable instance
    logic        bInValid, bInReady, bOutValid, bOutReady, bClrCnt;
    logic [12:0] bInCw;
    logic [7:0]  bOutData;
    logic        bOutNoError, bOutCorrected, bOutUncorr;
    logic [1:0]  bCorrCnt, bUncorrCnt;

    int errors = 0;
    int checks = 0;

    logic [4:0] dataCol [0:7] = '{5'h07, 5'h0B, 5'h0D, 5'h0E, 5'h13, 5'h15, 5'h16, 5'h19};

    fuec_13_8_rx_pipe dutA (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (inValid),
        .in_ready      (inReady),
        .in_cw         (inCw),
        .out_valid     (outValid),
        .out_ready     (outReady),
        .out_data      (outData),
        .out_no_error  (outNoError),
        .out_corrected (outCorrected),
        .out_uncorr    (outUncorr),
        .clr_cnt       (clrCnt),
        .corr_cnt      (corrCnt),
        .uncorr_cnt    (uncorrCnt)
    );

    fuec_13_8_rx_pipe #(.CNT_W(2), .DROP_UNCORR(1)) dutB (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (bInValid),
        .in_ready      (bInReady),
        .in_cw         (bInCw),
        .out_valid     (bOutValid),
        .out_ready     (bOutReady),
        .out_data      (bOutData),
        .out_no_error  (bOutNoError),
        .out_corrected (bOutCorrected),
        .out_uncorr    (bOutUncorr),
        .clr_cnt       (bClrCnt),
        .corr_cnt      (bCorrCnt),
        .uncorr_cnt    (bUncorrCnt)
    );

    // Parity-check column of codeword bit i
    function automatic logic [4:0] colOf(input int i);
        if (i < 8) return dataCol[i];
        return 5'(1 << (i - 8));
    endfunction

    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (d[i]) p ^= dataCol[i];
        return {p, d};
    endfunction

    function automatic logic [4:0] syndromeOf(input logic [12:0] cw);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < 13; i++) if (cw[i]) s ^= colOf(i);
        return s;
    endfunction

    // Returns {data, no_error, corrected, uncorr}
    function automatic logic [10:0] refDecode(input logic [12:0] cw);
        logic [4:0]  s;
        logic [12:0] f;
        s = syndromeOf(cw);
        if (s == 5'd0) return {cw[7:0], 3'b100};
        for (int i = 0; i < 13; i++) begin
            if (colOf(i) == s) begin
                f = cw ^ (13'd1 << i);
                return {f[7:0], 3'b010};
            end
        end
        return {cw[7:0], 3'b001};
    endfunction

    task test_reset;
        rst = 1'b1;
        inValid = 0; inCw = '0; outReady = 0; clrCnt = 0;
        bInValid = 0; bInCw = '0; bOutReady = 0; bClrCnt = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", outValid); end
        checks++;
        if ({outData, outNoError, outCorrected, outUncorr} !== 11'h000) begin
            errors++; $display("[TB] FAIL reset_out_fields got=%h exp=000", {outData, outNoError, outCorrected, outUncorr});
        end
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", inReady); end
        checks++;
        if ({corrCnt, uncorrCnt} !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters got=%h exp=0", {corrCnt, uncorrCnt}); end
        checks++;
        if ({bOutValid, bCorrCnt, bUncorrCnt} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_b_state got=%b exp=00000", {bOutValid, bCorrCnt, bUncorrCnt});
        end
        rst = 1'b0;
    endtask

    task test_no_error;
        @(negedge clk);
        inValid = 1; inCw = encode(8'hAC); outReady = 1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL noerr_in_ready got=%0b exp=1", inReady); end
        @(negedge clk);
        inValid = 0;
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL noerr_latency_early got=%0b exp=0", outValid); end
        @(negedge clk);
        checks++;
        if ({outValid, outData, outNoError, outCorrected, outUncorr} !== {1'b1, 8'hAC, 3'b100}) begin
            errors++; $display("[TB] FAIL noerr_output got=%h exp=%h", {outValid, outData, outNoError, outCorrected, outUncorr}, {1'b1, 8'hAC, 3'b100});
        end
        checks++;
        if ({corrCnt, uncorrCnt} !== 32'h0) begin errors++; $display("[TB] FAIL noerr_counters got=%h exp=0", {corrCnt, uncorrCnt}); end
    endtask

    task test_corrected;
        @(negedge clk);
        inValid = 1; inCw = encode(8'hAC) ^ 13'h008; outReady = 1;
        @(negedge clk);
        inValid = 0;
        @(negedge clk);
        checks++;
        if ({outValid, outData, outNoError, outCorrected, outUncorr} !== {1'b1, 8'hAC, 3'b010}) begin
            errors++; $display("[TB] FAIL corr_output got=%h exp=%h", {outValid, outData, outNoError, outCorrected, outUncorr}, {1'b1, 8'hAC, 3'b010});
        end
        checks++;
        if (corrCnt !== 16'd1) begin errors++; $display("[TB] FAIL corr_count got=%0d exp=1", corrCnt); end
    endtask

    task test_uncorr;
        logic [12:0] cw;
        cw = encode(8'hAC) ^ 13'h003;
        @(negedge clk);
        inValid = 1; inCw = cw; outReady = 1;
        @(negedge clk);
        inValid = 0;
        @(negedge clk);
        checks++;
        if ({outValid, outData, outNoError, outCorrected, outUncorr} !== {1'b1, 8'hAF, 3'b001}) begin
            errors++; $display("[TB] FAIL uncorr_output got=%h exp=%h", {outValid, outData, outNoError, outCorrected, outUncorr}, {1'b1, 8'hAF, 3'b001});
        end
        checks++;
        if ({corrCnt, uncorrCnt} !== {16'd1, 16'd1}) begin
            errors++; $display("[TB] FAIL uncorr_counts got=%0d/%0d exp=1/1", corrCnt, uncorrCnt);
        end
    endtask

    task test_clear;
        @(negedge clk);
        clrCnt = 1;
        @(negedge clk);
        clrCnt = 0;
        checks++;
        if ({corrCnt, uncorrCnt} !== 32'h0) begin errors++; $display("[TB] FAIL clear_counters got=%h exp=0", {corrCnt, uncorrCnt}); end
    endtask

    task test_back_to_back;
        logic [10:0] expQ[$];
        logic [10:0] exp;
        logic [10:0] prevOut;
        int sent, got;
        bit sawLow, stallPrev;
        sent = 0; got = 0; sawLow = 0; stallPrev = 0; prevOut = '0;
        for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
            @(negedge clk);
            if (stallPrev) begin
                checks++;
                if ({outValid, outData, outNoError, outCorrected, outUncorr} !== {1'b1, prevOut}) begin
                    errors++; $display("[TB] FAIL b2b_stall_stable got=%h exp=%h", {outValid, outData, outNoError, outCorrected, outUncorr}, {1'b1, prevOut});
                end
            end
            outReady = !(cyc >= 6 && cyc < 11);
            inValid = (sent < 16);
            inCw = encode(8'(sent));
            #1;
            if (outValid && outReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL b2b_unexpected got=%h exp=none", outData);
                end else begin
                    exp = expQ.pop_front();
                    if ({outData, outNoError, outCorrected, outUncorr} !== exp) begin
                        errors++; $display("[TB] FAIL b2b_order got=%h exp=%h", {outData, outNoError, outCorrected, outUncorr}, exp);
                    end
                end
                got++;
            end
            if (inValid && inReady) begin
                expQ.push_back(refDecode(inCw));
                sent++;
            end
            if (!inReady) sawLow = 1;
            stallPrev = outValid && !outReady;
            prevOut = {outData, outNoError, outCorrected, outUncorr};
        end
        inValid = 0;
        checks++;
        if (got != 16 || expQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=16", got); end
        checks++;
        if (!sawLow) begin errors++; $display("[TB] FAIL b2b_backpressure got=in_ready_never_low exp=in_ready_low"); end
    endtask

    task test_random;
        logic [10:0] expQ[$];
        logic [10:0] exp;
        logic [10:0] prevOut;
        logic [12:0] cw;
        int expCorr, expUnc, mode, b0, b1;
        bit stallPrev;
        expCorr = 0; expUnc = 0; stallPrev = 0; prevOut = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (stallPrev) begin
                checks++;
                if ({outValid, outData, outNoError, outCorrected, outUncorr} !== {1'b1, prevOut}) begin
                    errors++; $display("[TB] FAIL rand_stall_stable got=%h exp=%h", {outValid, outData, outNoError, outCorrected, outUncorr}, {1'b1, prevOut});
                end
            end
            inValid  = ($urandom_range(0, 3) != 0) && (cyc < 360);
            outReady = ($urandom_range(0, 3) != 0) || (cyc >= 360);
            cw   = encode(8'($urandom));
            mode = $urandom_range(0, 2);
            b0   = $urandom_range(0, 12);
            b1   = (b0 + $urandom_range(1, 12)) % 13;
            if (mode >= 1) cw[b0] = ~cw[b0];
            if (mode == 2) cw[b1] = ~cw[b1];
            inCw = cw;
            #1;
            if (outValid && outReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL rand_unexpected got=%h exp=none", outData);
                end else begin
                    exp = expQ.pop_front();
                    if ({outData, outNoError, outCorrected, outUncorr} !== exp) begin
                        errors++; $display("[TB] FAIL rand_data got=%h exp=%h", {outData, outNoError, outCorrected, outUncorr}, exp);
                    end
                end
            end
            if (inValid && inReady) begin
                exp = refDecode(cw);
                expQ.push_back(exp);
                if (exp[1]) expCorr++;
                if (exp[0]) expUnc++;
            end
            stallPrev = outValid && !outReady;
            prevOut = {outData, outNoError, outCorrected, outUncorr};
        end
        inValid = 0;
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL rand_drain got=%0d_left exp=0", expQ.size()); end
        checks++;
        if (corrCnt !== 16'(expCorr)) begin errors++; $display("[TB] FAIL rand_corr_cnt got=%0d exp=%0d", corrCnt, expCorr); end
        checks++;
        if (uncorrCnt !== 16'(expUnc)) begin errors++; $display("[TB] FAIL rand_uncorr_cnt got=%0d exp=%0d", uncorrCnt, expUnc); end
    endtask

    task test_drop;
        bit sawOut;
        sawOut = 0;
        @(negedge clk);
        bInValid = 1; bInCw = encode(8'h5A) ^ 13'h180; bOutReady = 1;
        #1;
        checks++;
        if (bInReady !== 1'b1) begin errors++; $display("[TB] FAIL drop_in_ready got=%0b exp=1", bInReady); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bInValid = 0;
            if (bOutValid) sawOut = 1;
        end
        checks++;
        if (sawOut) begin errors++; $display("[TB] FAIL drop_no_beat got=beat exp=none"); end
        checks++;
        if (bUncorrCnt !== 2'd1) begin errors++; $display("[TB] FAIL drop_uncorr_cnt got=%0d exp=1", bUncorrCnt); end
    endtask

    task test_saturation;
        bOutReady = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bInValid = 1; bInCw = encode(8'(i * 17)) ^ (13'd1 << i);
        end
        @(negedge clk);
        bInValid = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bCorrCnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_corr_cnt got=%0d exp=3", bCorrCnt); end
        bInValid = 1; bInCw = encode(8'h3C) ^ 13'h010;
        @(negedge clk);
        bInValid = 0; bClrCnt = 1;
        @(negedge clk);
        bClrCnt = 0;
        checks++;
        if (bCorrCnt !== 2'd0) begin errors++; $display("[TB] FAIL sat_clear_wins got=%0d exp=0", bCorrCnt); end
        checks++;
        if ({bOutValid, bOutData, bOutNoError, bOutCorrected, bOutUncorr} !== {1'b1, 8'h3C, 3'b010}) begin
            errors++; $display("[TB] FAIL sat_clear_word got=%h exp=%h", {bOutValid, bOutData, bOutNoError, bOutCorrected, bOutUncorr}, {1'b1, 8'h3C, 3'b010});
        end
    endtask

    task test_reset_midflight;
        bit sawStale;
        sawStale = 0;
        @(negedge clk);
        outReady = 0; inValid = 1; inCw = encode(8'h11) ^ 13'h001;
        @(negedge clk);
        inCw = encode(8'h22);
        @(negedge clk);
        inValid = 0;
        checks++;
        if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL mid_inflight got=%0b exp=1", outValid); end
        #2;
        rst = 1;
        #1;
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_drop got=%0b exp=0", outValid); end
        checks++;
        if ({corrCnt, uncorrCnt} !== 32'h0) begin errors++; $display("[TB] FAIL mid_counters got=%h exp=0", {corrCnt, uncorrCnt}); end
        @(negedge clk);
        rst = 0; outReady = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (outValid) sawStale = 1;
        end
        checks++;
        if (sawStale) begin errors++; $display("[TB] FAIL mid_stale_word got=beat exp=none"); end
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready got=%0b exp=1", inReady); end
    endtask

    initial begin
        $display("[TB] starting fuec_13_8_rx_pipe bench");
        test_reset;
        test_no_error;
        test_corrected;
        test_uncorr;
        test_clear;
        test_back_to_back;
        test_random;
        test_drop;
        test_saturation;
        test_reset_midflight;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
